// File: rtl/insn_fetch_if.sv
// Fetch-stage bus bundle: opcode byte, bus ready, fetch request, interrupt pins
// and the delivered instruction with its source tag.
//   master : decoder/bus side (drives data_in, rdy, fetch_req, nmi, irq, i_flag)
//   slave  : insn_fetch side (drives insn, insn_valid, int_src, sync)
interface insn_fetch_if;
    logic [7:0] data_in;
    logic       rdy;
    logic       fetch_req;
    logic       nmi;
    logic       irq;
    logic       i_flag;
    logic [7:0] insn;
    logic       insn_valid;
    logic [1:0] int_src;
    logic       sync;

    modport master (
        output data_in, rdy, fetch_req, nmi, irq, i_flag,
        input  insn, insn_valid, int_src, sync
    );

    modport slave (
        input  data_in, rdy, fetch_req, nmi, irq, i_flag,
        output insn, insn_valid, int_src, sync
    );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch + interrupt injection: latches the opcode on a fetch,
// replacing it with BRK for reset/NMI/IRQ, and tags the source in int_src.
// Ports: clk, rst (sync, active-high), bus (insn_fetch_if.slave).
// Optional INSN_FETCH_SO_EN: adds so (active-low pin) and set_v (edge pulse).
module insn_fetch #(
    parameter int unsigned RESET_DELAY = 2,
    parameter logic [7:0]  BRK_OPCODE  = 8'h00
) (
    input  logic         clk,
    input  logic         rst,
    insn_fetch_if.slave  bus
`ifdef INSN_FETCH_SO_EN
    ,
    input  logic         so,
    output logic         set_v
`endif
);
    typedef enum logic [1:0] {
        RST_WAIT,
        IDLE,
        FETCH,
        DELIVER
    } state_e;

    localparam logic [1:0] SRC_NORM = 2'b00;
    localparam logic [1:0] SRC_IRQ  = 2'b01;
    localparam logic [1:0] SRC_NMI  = 2'b10;
    localparam logic [1:0] SRC_RST  = 2'b11;

    localparam logic [3:0] CNT_LAST = 4'(RESET_DELAY - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] insn_q, insn_d;
    logic [1:0] src_q, src_d;
    logic       valid_q, valid_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic       nmi_prev_q;
    logic       nmi_clr;
    logic       nmi_edge;

    assign nmi_edge = nmi_prev_q & ~bus.nmi;
    // A fresh edge beats the clear, so back-to-back NMIs are not lost.
    assign nmi_pend_d = nmi_edge | (nmi_pend_q & ~nmi_clr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        insn_d  = insn_q;
        src_d   = src_q;
        valid_d = 1'b0;
        nmi_clr = 1'b0;
        unique case (state_q)
            RST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = DELIVER;
                    insn_d  = BRK_OPCODE;
                    src_d   = SRC_RST;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            IDLE: begin
                if (bus.fetch_req) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (bus.rdy) begin
                    state_d = IDLE;
                    valid_d = 1'b1;
                    if (nmi_pend_q) begin
                        insn_d  = BRK_OPCODE;
                        src_d   = SRC_NMI;
                        nmi_clr = 1'b1;
                    end else if (!bus.irq && !bus.i_flag) begin
                        insn_d = BRK_OPCODE;
                        src_d  = SRC_IRQ;
                    end else begin
                        insn_d = bus.data_in;
                        src_d  = SRC_NORM;
                    end
                end
            end
            DELIVER: begin
                state_d = IDLE;
            end
            default: begin
                state_d = RST_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_WAIT;
            cnt_q      <= 4'd0;
            insn_q     <= 8'h00;
            src_q      <= SRC_NORM;
            valid_q    <= 1'b0;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            insn_q     <= insn_d;
            src_q      <= src_d;
            valid_q    <= valid_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= bus.nmi;
        end
    end

    assign bus.insn       = insn_q;
    assign bus.int_src    = src_q;
    assign bus.insn_valid = valid_q;
    assign bus.sync       = (state_q == FETCH);

`ifdef INSN_FETCH_SO_EN
    logic so_prev_q;
    logic set_v_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            so_prev_q <= 1'b1;
            set_v_q   <= 1'b0;
        end else begin
            so_prev_q <= so;
            set_v_q   <= so_prev_q & ~so;
        end
    end

    assign set_v = set_v_q;
`endif
endmodule
